// File: rtl/lcd_spi_write_if.sv
// Upstream write port of lcd_spi_write: level request, 9-bit {dc,byte} word, done pulse.
// Handshake: a word is taken on the sys_clk edge where the writer is idle and en_write=1;
// wr_done pulses for one cycle per taken word and is the only completion indication.
interface lcd_spi_write_if;
    logic       en_write;
    logic [8:0] wr_data;
    logic       wr_done;

    modport master (output en_write, output wr_data, input  wr_done);
    modport slave  (input  en_write, input  wr_data, output wr_done);
endinterface

// File: rtl/lcd_spi_write.sv
// SPI mode-0 byte writer for the LCD controller, one chip select per {dc,byte} word.
// Optional macro LCD_SPI_TX_CNT_EN adds a 16-bit completed-byte counter output tx_cnt.
module lcd_spi_write #(
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 4
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    lcd_spi_write_if.slave  wr_if,
    output logic            lcd_sclk,
    output logic            lcd_mosi,
    output logic            lcd_cs_n,
    output logic            lcd_dc,
`ifdef LCD_SPI_TX_CNT_EN
    output logic [15:0]     tx_cnt,
`endif
    output logic [1:0]      dbg_state
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int GAP_W = $clog2(GAP_CYC) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       shift_reg;   // bit 7 goes straight to mosi when the word is taken
    logic             wr_done_q;

    assign wr_if.wr_done = wr_done_q;
    assign dbg_state     = state;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            wr_done_q <= 1'b0;
            lcd_sclk  <= 1'b0;
            lcd_mosi  <= 1'b0;
            lcd_cs_n  <= 1'b1;
            lcd_dc    <= 1'b0;
`ifdef LCD_SPI_TX_CNT_EN
            tx_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (wr_if.en_write) begin
                        shift_reg <= wr_if.wr_data[6:0];
                        lcd_mosi  <= wr_if.wr_data[7];
                        lcd_dc    <= wr_if.wr_data[8];
                        lcd_cs_n  <= 1'b0;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        lcd_sclk <= ~lcd_sclk;
                        if (!lcd_sclk) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (bit_cnt == 3'd0) begin
                            // bit_cnt wrapped after the 8th rising edge: this is the final falling edge
                            wr_done_q <= 1'b1;
                            lcd_cs_n  <= 1'b1;
                            state     <= DONE;
                        end else begin
                            lcd_mosi  <= shift_reg[6];
                            shift_reg <= {shift_reg[5:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DONE: begin
                    wr_done_q <= 1'b0;
                    gap_cnt   <= '0;
                    state     <= GAP;
`ifdef LCD_SPI_TX_CNT_EN
                    tx_cnt    <= tx_cnt + 16'd1;
`endif
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_spi_write.sv
// Randomized scoreboard bench for lcd_spi_write (CLK_DIV=2/GAP_CYC=4 main instance,
// CLK_DIV=1/GAP_CYC=2 second instance); tx_cnt checks only with LCD_SPI_TX_CNT_EN.
module tb_lcd_spi_write;

    localparam int CD  = 2;
    localparam int GC  = 4;
    localparam int BYTE_CYC = 16 * CD;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    always #5 sys_clk = ~sys_clk;

    lcd_spi_write_if wif0();
    lcd_spi_write_if wif1();

    logic sclk0, mosi0, cs0, dc0, sclk1, mosi1, cs1, dc1;
    logic [1:0] dbg0, dbg1;
`ifdef LCD_SPI_TX_CNT_EN
    logic [15:0] tx_cnt0, tx_cnt1;
`endif

    lcd_spi_write #(.CLK_DIV(CD), .GAP_CYC(GC)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_if(wif0),
        .lcd_sclk(sclk0), .lcd_mosi(mosi0), .lcd_cs_n(cs0), .lcd_dc(dc0),
`ifdef LCD_SPI_TX_CNT_EN
        .tx_cnt(tx_cnt0),
`endif
        .dbg_state(dbg0)
    );

    lcd_spi_write #(.CLK_DIV(1), .GAP_CYC(2)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_if(wif1),
        .lcd_sclk(sclk1), .lcd_mosi(mosi1), .lcd_cs_n(cs1), .lcd_dc(dc1),
`ifdef LCD_SPI_TX_CNT_EN
        .tx_cnt(tx_cnt1),
`endif
        .dbg_state(dbg1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard: expected word and wr_done cycle ----------------
    logic [8:0] exp_q[$];
    int         exp_t_q[$];
    int         next_free = 0;
    logic [15:0] cnt_model = '0;

    // ---------------- monitor for the main instance ----------------
    logic       m_prev_sclk = 1'b0;
    int         m_nbits = 0;
    logic [7:0] m_acc = '0;
    logic       m_dc = 1'b0;
    int         m_last_rise = 0;
    logic       m_period_bad = 1'b0;
    logic       m_dc_bad = 1'b0;
    logic [8:0] m_exp;
    int         m_exp_t;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            m_prev_sclk = 1'b0; m_nbits = 0; m_acc = '0;
            m_period_bad = 1'b0; m_dc_bad = 1'b0;
        end else begin
            if (sclk0 && !m_prev_sclk) begin
                chk("cs_n_low_at_rise", cs0, 1'b0);
                if (m_nbits > 0 && (cyc - m_last_rise) != 2 * CD) m_period_bad = 1'b1;
                if (m_nbits == 0) m_dc = dc0;
                else if (dc0 !== m_dc) m_dc_bad = 1'b1;
                m_last_rise = cyc;
                m_acc = {m_acc[6:0], mosi0};
                m_nbits++;
            end
            m_prev_sclk = sclk0;
            if (wif0.wr_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr_done", wif0.wr_done, 1'b0);
                end else begin
                    m_exp   = exp_q.pop_front();
                    m_exp_t = exp_t_q.pop_front();
                    chk("word", {m_dc, m_acc}, m_exp);
                    chk("done_cycle", cyc, m_exp_t);
                    chk("bit_count", m_nbits, 8);
                    chk("sclk_period_dc_stable", {m_period_bad, m_dc_bad}, 2'b00);
                    chk("cs_n_high_at_done", cs0, 1'b1);
                    chk("sclk_low_at_done", sclk0, 1'b0);
                end
                m_nbits = 0; m_period_bad = 1'b0; m_dc_bad = 1'b0;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_idle();
        while (cyc < next_free) @(negedge sys_clk);
    endtask

    // Called on a negedge; the word is sampled at the following posedge.
    task automatic send(input logic [8:0] d, input bit hold);
        wait_idle();
        wif0.en_write = 1'b1;
        wif0.wr_data  = d;
        exp_q.push_back(d);
        exp_t_q.push_back(cyc + 1 + BYTE_CYC);
        next_free = cyc + 2 + BYTE_CYC + GC;
        cnt_model = cnt_model + 16'd1;
        @(negedge sys_clk);
        if (!hold) wif0.en_write = 1'b0;
        wif0.wr_data = 9'($urandom_range(0, 511));
    endtask

    task automatic abort_byte(input logic [8:0] d);
        int t0;
        send(d, 1'b0);
        t0 = cyc - 1;
        // third sclk rising edge is visible from cycle t0+11
        while (cyc < t0 + 12) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("abort_cs_n", cs0, 1'b1);
        chk("abort_sclk", sclk0, 1'b0);
        chk("abort_wr_done", wif0.wr_done, 1'b0);
        void'(exp_q.pop_back());
        void'(exp_t_q.pop_back());
        cnt_model = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        next_free = cyc;
    endtask

    task automatic check_tx();
`ifdef LCD_SPI_TX_CNT_EN
        wait_idle();
        chk("tx_cnt", tx_cnt0, cnt_model);
`endif
    endtask

    // Second instance: one word, observed for 20 cycles from its accept cycle.
    task automatic dut1_byte(input logic [8:0] d);
        int t0, nb, ndone, done_at;
        logic ps;
        logic [7:0] acc;
        logic dcv;
        t0 = cyc; nb = 0; ndone = 0; done_at = -1; ps = 1'b0; acc = '0; dcv = 1'b0;
        wif1.en_write = 1'b1;
        wif1.wr_data  = d;
        for (int i = 1; i <= 20; i++) begin
            @(negedge sys_clk);
            if (i == 1) begin
                wif1.en_write = 1'b0;
                wif1.wr_data  = 9'($urandom_range(0, 511));
            end
            if (sclk1 && !ps) begin
                acc = {acc[6:0], mosi1};
                dcv = dc1;
                nb++;
            end
            ps = sclk1;
            if (wif1.wr_done) begin
                ndone++;
                done_at = cyc;
            end
        end
        chk("div1_done_cycle", done_at - t0, 17);
        chk("div1_done_count", ndone, 1);
        chk("div1_word", {dcv, acc}, d);
        chk("div1_bit_count", nb, 8);
    endtask

    initial begin
        #2000000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [8:0] d;
        bit hold;
        sys_rst_n = 1'b0;
        wif0.en_write = 1'b0; wif0.wr_data = '0;
        wif1.en_write = 1'b0; wif1.wr_data = '0;
        repeat (3) @(negedge sys_clk);
        chk("rst_cs_n", cs0, 1'b1);
        chk("rst_sclk", sclk0, 1'b0);
        chk("rst_mosi", mosi0, 1'b0);
        chk("rst_dc", dc0, 1'b0);
        chk("rst_wr_done", wif0.wr_done, 1'b0);
        chk("rst_state_idle", dbg0, 2'd0);
        chk("rst_cs_n_div1", cs1, 1'b1);
`ifdef LCD_SPI_TX_CNT_EN
        chk("rst_tx_cnt", tx_cnt0, 16'd0);
`endif
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        next_free = cyc;

        // fast instance: accept, wr_done at +17, next accept at +20
        dut1_byte(9'h0FF);
        dut1_byte(9'h155);

        // directed command, data and back-to-back words
        send(9'h02A, 1'b0);
        send(9'h1A5, 1'b0);
        send(9'h02B, 1'b1);
        while (cyc < next_free - 3) @(negedge sys_clk);
        wif0.wr_data = 9'h100;
        send(9'h100, 1'b0);

        // random words, some back-to-back with en_write held
        hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!hold) repeat ($urandom_range(0, 5)) @(negedge sys_clk);
            hold = ($urandom_range(0, 3) == 0) && (i != 19);
            d = 9'($urandom_range(0, 511));
            send(d, hold);
        end
        check_tx();

        // reset mid-byte, then three good bytes and another abort
        abort_byte(9'h1C3);
        for (int i = 0; i < 3; i++) send(9'($urandom_range(0, 511)), 1'b0);
        check_tx();
        abort_byte(9'h0F0);
        check_tx();

`ifdef LCD_SPI_TX_CNT_EN
        wait_idle();
        force dut0.tx_cnt = 16'hFFFF;
        @(negedge sys_clk);
        release dut0.tx_cnt;
        cnt_model = 16'hFFFF;
        send(9'h055, 1'b0);
        check_tx();
`endif

        send(9'($urandom_range(0, 511)), 1'b0);
        wait_idle();
        repeat (4) @(negedge sys_clk);
        chk("pending_expected", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
